// File: rtl/enigma_sequencer.sv
// Enigma letter sequencer: holds rotor config, steps rotors, runs 7 passes through a shared LUT.
// Latency: 9 cycles from letter acceptance to char_valid_out with a zero-wait LUT, plus 1 per LUT wait cycle.
// Backpressure: LUT request fields are held until lut_valid_in; new pulses are dropped while busy_out is high.
module enigma_sequencer #(
  parameter logic [34:0] NOTCH_PACKED = {5'd25, 5'd25, 5'd25, 5'd9, 5'd21, 5'd4, 5'd16},
  parameter logic [2:0]  REFLECTOR_ID = 3'd7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rotor_valid_in,
  input  logic [8:0]  rotor_select_in,
  input  logic [14:0] rotor_initial_in,
  input  logic        letter_valid_in,
  input  logic [4:0]  char_in,
  output logic        lut_req_out,
  output logic [2:0]  lut_rotor_out,
  output logic        lut_dir_out,
  output logic [4:0]  lut_char_out,
  input  logic        lut_valid_in,
  input  logic [4:0]  lut_char_in,
  output logic [4:0]  char_out,
  output logic        char_valid_out,
  output logic        busy_out,
  output logic [14:0] positions_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] LOOKUP = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic [2:0] pass;
  logic [2:0] sel_l, sel_m, sel_r;
  logic [4:0] pos_l, pos_m, pos_r;
  logic [4:0] cur;
  logic [4:0] char_q;
  logic       valid_q;

  logic [2:0] pass_rotor;
  logic       pass_dir;
  logic [4:0] pass_pos;
  logic [4:0] fwd_char;
  logic [4:0] back_char;
  logic       right_at_notch;
  logic       mid_at_notch;
  logic       in_lookup;

  // Turnover position for a rotor id; id 7 never carries a rotor, treated as Z.
  function automatic logic [4:0] notch_of(input logic [2:0] id);
    logic [39:0] ext;
    ext = {5'd25, NOTCH_PACKED};
    return ext[{3'b000, id} * 6'd5 +: 5];
  endfunction

  // Reduce a 0..51 value into 0..25.
  function automatic logic [4:0] mod26(input logic [5:0] v);
    logic [5:0] r;
    r = (v >= 6'd26) ? (v - 6'd26) : v;
    return r[4:0];
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : (v + 5'd1);
  endfunction

  // Select rotor, direction and offset for the current pass; reflector uses no offset.
  always_comb begin
    pass_rotor = sel_r;
    pass_dir   = 1'b0;
    pass_pos   = pos_r;
    case (pass)
      3'd0: begin pass_rotor = sel_r;        pass_pos = pos_r; pass_dir = 1'b0; end
      3'd1: begin pass_rotor = sel_m;        pass_pos = pos_m; pass_dir = 1'b0; end
      3'd2: begin pass_rotor = sel_l;        pass_pos = pos_l; pass_dir = 1'b0; end
      3'd3: begin pass_rotor = REFLECTOR_ID; pass_pos = 5'd0;  pass_dir = 1'b0; end
      3'd4: begin pass_rotor = sel_l;        pass_pos = pos_l; pass_dir = 1'b1; end
      3'd5: begin pass_rotor = sel_m;        pass_pos = pos_m; pass_dir = 1'b1; end
      default: begin pass_rotor = sel_r;     pass_pos = pos_r; pass_dir = 1'b1; end
    endcase
    fwd_char  = mod26({1'b0, cur} + {1'b0, pass_pos});
    back_char = mod26({1'b0, lut_char_in} + 6'd26 - {1'b0, pass_pos});
  end

  assign right_at_notch = (pos_r == notch_of(sel_r));
  assign mid_at_notch   = (pos_m == notch_of(sel_m));
  assign in_lookup      = (state == LOOKUP);

  assign lut_req_out    = in_lookup;
  assign lut_rotor_out  = in_lookup ? pass_rotor : 3'd0;
  assign lut_dir_out    = in_lookup ? pass_dir : 1'b0;
  assign lut_char_out   = in_lookup ? fwd_char : 5'd0;
  assign busy_out       = (state != IDLE);
  assign positions_out  = {pos_l, pos_m, pos_r};
  assign char_out       = char_q;
  assign char_valid_out = valid_q;

  // Sequencer FSM: config/letter capture, rotor stepping, LUT pass scheduling, result emission.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      pass    <= 3'd0;
      sel_l   <= 3'd0;
      sel_m   <= 3'd1;
      sel_r   <= 3'd2;
      pos_l   <= 5'd0;
      pos_m   <= 5'd0;
      pos_r   <= 5'd0;
      cur     <= 5'd0;
      char_q  <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rotor_valid_in) begin
            sel_l <= rotor_select_in[8:6];
            sel_m <= rotor_select_in[5:3];
            sel_r <= rotor_select_in[2:0];
            pos_l <= rotor_initial_in[14:10];
            pos_m <= rotor_initial_in[9:5];
            pos_r <= rotor_initial_in[4:0];
          end
          if (letter_valid_in && (char_in <= 5'd25)) begin
            cur   <= char_in;
            state <= STEP;
          end
        end
        STEP: begin
          // Middle also steps when it sits on its own notch: the double step.
          pos_r <= inc26(pos_r);
          if (right_at_notch || mid_at_notch) pos_m <= inc26(pos_m);
          if (mid_at_notch) pos_l <= inc26(pos_l);
          pass  <= 3'd0;
          state <= LOOKUP;
        end
        LOOKUP: begin
          if (lut_valid_in) begin
            cur <= back_char;
            if (pass == 3'd6) begin
              state <= DONE;
            end else begin
              pass <= pass + 3'd1;
            end
          end
        end
        default: begin
          char_q  <= cur;
          valid_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_sequencer.sv
module tb_enigma_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rotor_valid_in;
  logic [8:0]  rotor_select_in;
  logic [14:0] rotor_initial_in;
  logic        letter_valid_in;
  logic [4:0]  char_in;
  logic        lut_req_out;
  logic [2:0]  lut_rotor_out;
  logic        lut_dir_out;
  logic [4:0]  lut_char_out;
  logic        lut_valid_in;
  logic [4:0]  lut_char_in;
  logic [4:0]  char_out;
  logic        char_valid_out;
  logic        busy_out;
  logic [14:0] positions_out;

  always #5 clk_in = ~clk_in;

  enigma_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .rotor_valid_in(rotor_valid_in), .rotor_select_in(rotor_select_in),
    .rotor_initial_in(rotor_initial_in),
    .letter_valid_in(letter_valid_in), .char_in(char_in),
    .lut_req_out(lut_req_out), .lut_rotor_out(lut_rotor_out),
    .lut_dir_out(lut_dir_out), .lut_char_out(lut_char_out),
    .lut_valid_in(lut_valid_in), .lut_char_in(lut_char_in),
    .char_out(char_out), .char_valid_out(char_valid_out),
    .busy_out(busy_out), .positions_out(positions_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- wiring tables and reference model ----------------
  int wf[8][26];
  int wb[8][26];
  int notch_t[7] = '{16, 4, 21, 9, 25, 25, 25};
  int m_sel[3];   // 0 = right, 1 = middle, 2 = left
  int m_pos[3];

  task automatic init_tables();
    string w[8];
    w[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    w[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    w[2] = "BDFHJLCPRTXVZNYEQOSKAIUMWG";
    w[3] = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    w[4] = "VZBRGITYUPSDNHLXAWMJQOFECK";
    w[5] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    w[6] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    w[7] = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 26; i++) begin
        wf[r][i] = int'(w[r][i]) - 65;
      end
      for (int i = 0; i < 26; i++) wb[r][wf[r][i]] = i;
    end
  endtask

  function automatic int pass_through(input int id, input int pos, input int c, input bit inv);
    int x;
    x = (c + pos) % 26;
    x = inv ? wb[id][x] : wf[id][x];
    return (x - pos + 26) % 26;
  endfunction

  task automatic model_reset();
    m_sel[0] = 2; m_sel[1] = 1; m_sel[2] = 0;
    m_pos[0] = 0; m_pos[1] = 0; m_pos[2] = 0;
  endtask

  task automatic model_letter(input int c, output int ct, output logic [14:0] p);
    bit rt;
    bit mt;
    int x;
    rt = (m_pos[0] == notch_t[m_sel[0]]);
    mt = (m_pos[1] == notch_t[m_sel[1]]);
    m_pos[0] = (m_pos[0] + 1) % 26;
    if (rt || mt) m_pos[1] = (m_pos[1] + 1) % 26;
    if (mt) m_pos[2] = (m_pos[2] + 1) % 26;
    x = c;
    for (int i = 0; i < 3; i++) x = pass_through(m_sel[i], m_pos[i], x, 1'b0);
    x = wf[7][x];
    for (int i = 2; i >= 0; i--) x = pass_through(m_sel[i], m_pos[i], x, 1'b1);
    ct = x;
    p = {5'(m_pos[2]), 5'(m_pos[1]), 5'(m_pos[0])};
  endtask

  function automatic logic [14:0] model_positions();
    return {5'(m_pos[2]), 5'(m_pos[1]), 5'(m_pos[0])};
  endfunction

  // ---------------- LUT responder with programmable wait ----------------
  int         lut_wait = 0;
  logic [3:0] wait_cnt = 4'd0;

  function automatic logic [4:0] lut_fn(input logic [2:0] rot, input logic dir, input logic [4:0] ch);
    if (ch > 5'd25) return 5'd0;
    return dir ? 5'(wb[rot][ch]) : 5'(wf[rot][ch]);
  endfunction

  assign lut_valid_in = lut_req_out && (int'(wait_cnt) >= lut_wait);
  assign lut_char_in  = lut_fn(lut_rotor_out, lut_dir_out, lut_char_out);

  always @(posedge clk_in) begin
    if (lut_req_out && !lut_valid_in) wait_cnt <= wait_cnt + 4'd1;
    else wait_cnt <= 4'd0;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          ch;
    logic [14:0] pos;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Output monitor: every char_valid_out pulse must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk_in);
      if (char_valid_out) begin
        if (sbq.size() == 0) begin
          check("unexpected_char_valid", int'(char_valid_out), 0);
        end else begin
          mon_e = sbq.pop_front();
          check("char_out", int'(char_out), mon_e.ch);
          check("positions_at_output", int'(positions_out), int'(mon_e.pos));
          check("latency_cycle", cyc, mon_e.due);
        end
      end
    end
  end

  // Request monitor: LUT request fields must hold while the LUT stalls.
  logic       prev_req = 1'b0;
  logic       prev_vld = 1'b0;
  logic [8:0] prev_sig = 9'd0;
  initial begin
    forever begin
      @(negedge clk_in);
      if (lut_req_out && prev_req && !prev_vld)
        check("lut_fields_stable", int'({lut_rotor_out, lut_dir_out, lut_char_out}), int'(prev_sig));
      prev_req = lut_req_out;
      prev_vld = lut_valid_in;
      prev_sig = {lut_rotor_out, lut_dir_out, lut_char_out};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit rv, input logic [8:0] sel, input logic [14:0] init,
                       input bit lv, input logic [4:0] ch);
    exp_t e;
    @(negedge clk_in);
    rotor_valid_in   = rv;
    rotor_select_in  = sel;
    rotor_initial_in = init;
    letter_valid_in  = lv;
    char_in          = ch;
    if (rv) begin
      m_sel[0] = int'(sel[2:0]);   m_sel[1] = int'(sel[5:3]);    m_sel[2] = int'(sel[8:6]);
      m_pos[0] = int'(init[4:0]);  m_pos[1] = int'(init[9:5]);   m_pos[2] = int'(init[14:10]);
    end
    if (lv && ch <= 5'd25) begin
      model_letter(int'(ch), e.ch, e.pos);
      e.due = cyc + 1 + 9 + 7 * lut_wait;
      sbq.push_back(e);
    end
    @(negedge clk_in);
    rotor_valid_in  = 1'b0;
    letter_valid_in = 1'b0;
  endtask

  // Drive pulses the model must not see (DUT busy or about to be reset).
  task automatic poke(input bit rv, input logic [8:0] sel, input logic [14:0] init,
                      input bit lv, input logic [4:0] ch);
    @(negedge clk_in);
    rotor_valid_in   = rv;
    rotor_select_in  = sel;
    rotor_initial_in = init;
    letter_valid_in  = lv;
    char_in          = ch;
    @(negedge clk_in);
    rotor_valid_in  = 1'b0;
    letter_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (sbq.size() == 0) break;
    end
    check({name, "_drained"}, sbq.size(), 0);
    sbq.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [8:0]  rsel;
    logic [14:0] rinit;
    logic [4:0]  rch;
    bit          rrv;

    init_tables();
    model_reset();
    rst_in = 1'b1;
    rotor_valid_in = 1'b0; rotor_select_in = 9'd0; rotor_initial_in = 15'd0;
    letter_valid_in = 1'b0; char_in = 5'd0;
    repeat (3) @(negedge clk_in);
    check("rst_char_out", int'(char_out), 0);
    check("rst_char_valid", int'(char_valid_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_positions", int'(positions_out), 0);
    check("rst_lut_bus", int'({lut_req_out, lut_rotor_out, lut_dir_out, lut_char_out}), 0);
    rst_in = 1'b0;

    // Known-answer: I-II-III at AAA, letter A encrypts to B
    issue(1'b1, 9'b000_001_010, 15'd0, 1'b0, 5'd0);
    check("cfg_positions", int'(positions_out), 0);
    check("cfg_busy", int'(busy_out), 0);
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd0);
    wait_idle("kat");
    check("kat_char_B", int'(char_out), 1);
    check("kat_positions", int'(positions_out), int'({5'd0, 5'd0, 5'd1}));

    // Double step from ADV
    issue(1'b1, 9'b000_001_010, {5'd0, 5'd3, 5'd21}, 1'b0, 5'd0);
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd7);
    wait_idle("dstep1");
    check("dstep_AEW", int'(positions_out), int'({5'd0, 5'd4, 5'd22}));
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd11);
    wait_idle("dstep2");
    check("dstep_BFX", int'(positions_out), int'({5'd1, 5'd5, 5'd23}));
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd25);
    wait_idle("dstep3");
    check("dstep_BFY", int'(positions_out), int'({5'd1, 5'd5, 5'd24}));

    // Right rotor wraps 25 -> 0 without moving the middle
    issue(1'b1, 9'b000_001_010, {5'd0, 5'd0, 5'd25}, 1'b1, 5'd3);
    wait_idle("wrap");
    check("wrap_positions", int'(positions_out), 0);

    // Slow LUT: three wait cycles per pass
    lut_wait = 3;
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd19);
    wait_idle("slow_lut");
    lut_wait = 0;

    // Pulses while busy are ignored
    lut_wait = 1;
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd4);
    repeat (2) @(negedge clk_in);
    poke(1'b0, 9'd0, 15'd0, 1'b1, 5'd9);
    poke(1'b1, 9'b100_011_001, {5'd7, 5'd8, 5'd9}, 1'b0, 5'd0);
    poke(1'b1, 9'b011_100_000, {5'd1, 5'd2, 5'd3}, 1'b1, 5'd2);
    wait_idle("busy_ignore");
    repeat (3) @(negedge clk_in);
    check("busy_ignore_positions", int'(positions_out), int'(model_positions()));
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd12);
    wait_idle("busy_after");
    lut_wait = 0;

    // Config and letter in the same cycle, then an out-of-range letter
    issue(1'b1, 9'b000_001_010, {5'd0, 5'd0, 5'd5}, 1'b1, 5'd14);
    wait_idle("simul");
    check("simul_positions", int'(positions_out), int'({5'd0, 5'd0, 5'd6}));
    issue(1'b0, 9'd0, 15'd0, 1'b1, 5'd27);
    repeat (15) @(negedge clk_in);
    check("bad_char_positions", int'(positions_out), int'({5'd0, 5'd0, 5'd6}));
    check("bad_char_busy", int'(busy_out), 0);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      lut_wait = $urandom_range(0, 2);
      rrv   = ($urandom_range(0, 3) == 0);
      rsel  = {3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6))};
      rinit = {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
      rch   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      issue(rrv, rsel, rinit, 1'b1, rch);
      wait_idle("random");
      repeat (2) @(negedge clk_in);
      check("random_positions", int'(positions_out), int'(model_positions()));
    end
    lut_wait = 0;

    // Reset during pass 4 abandons the letter
    poke(1'b0, 9'd0, 15'd0, 1'b1, 5'd6);
    repeat (5) @(negedge clk_in);
    check("midrst_in_lookup", int'(lut_req_out), 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_busy", int'(busy_out), 0);
    check("midrst_lut_req", int'(lut_req_out), 0);
    check("midrst_outputs", int'({char_out, char_valid_out, positions_out}), 0);
    rst_in = 1'b0;
    model_reset();
    repeat (15) @(negedge clk_in);
    check("midrst_idle_positions", int'(positions_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enigma_sequencer.md
Name: enigma_sequencer

Overview:
Sequences one Enigma encryption per accepted letter. It holds the rotor selection and positions, steps the rotors (including double-step), then schedules seven passes through a single shared substitution lookup unit: three rotors forward, reflector, three rotors backward. It sits between the switch/button capture stage and the rotor wiring LUT, and drives the encrypted character and live rotor positions to the display.

Parameters:
NOTCH_PACKED, {5'd25,5'd25,5'd25,5'd9,5'd21,5'd4,5'd16}, per-rotor-id turnover position. Field [5i+4:5i] is rotor id i, ids 0..6 (I=Q, II=E, III=V, IV=J, V=Z, ids 5-6=Z).
REFLECTOR_ID, 3'd7, rotor id presented to the LUT for the reflector pass.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rotor_valid_in  input  1  one-cycle pulse; apply new configuration
rotor_select_in  input  9  [8:6] left id, [5:3] middle id, [2:0] right id
rotor_initial_in  input  15  [14:10] left, [9:5] middle, [4:0] right start position, 0..25
letter_valid_in  input  1  one-cycle pulse; encrypt char_in
char_in  input  5  plaintext letter, 0..25
lut_req_out  output  1  lookup request
lut_rotor_out  output  3  rotor id for the lookup
lut_dir_out  output  1  0 = forward wiring, 1 = inverse wiring
lut_char_out  output  5  contact index presented to the LUT
lut_valid_in  input  1  lookup result valid
lut_char_in  input  5  lookup result, 0..25
char_out  output  5  ciphertext letter
char_valid_out  output  1  one-cycle pulse with char_out
busy_out  output  1  high outside IDLE
positions_out  output  15  current positions, same packing as rotor_initial_in

Behaviour:
- Reset: every output is 0. Selection regs reset to {0,1,2} (I, II, III), positions to 0, FSM to IDLE.
- States: IDLE, STEP, LOOKUP (pass counter p = 0..6), DONE.
- IDLE:
  - rotor_valid_in loads the selection and positions.
  - letter_valid_in with char_in <= 25 latches the character and moves to STEP.
  - char_in >= 26 is dropped with no stepping and no output.
  - If both pulses arrive in the same cycle, the config is applied and the letter is encrypted from the new positions.
- busy_out is high in every state except IDLE. Both pulses are ignored entirely while busy; there is no queueing.
- STEP (1 cycle), evaluated on the pre-step values:
  - Right always steps.
  - Middle steps if right == notch(right id), or if middle == notch(middle id). The second condition is the double step.
  - Left steps if middle == notch(middle id).
  - Position increments wrap 25 -> 0.
  - positions_out reflects the new positions the cycle after STEP.
- LOOKUP pass order:
  - p = 0..2: right, middle, left, with dir = 0.
  - p = 3: reflector, with lut_rotor_out = REFLECTOR_ID and no offset applied.
  - p = 4..6: left, middle, right, with dir = 1.
- Offset arithmetic, mod 26 using 6-bit intermediates:
  - lut_char_out = (c + pos) mod 26.
  - Returned c' = (lut_char_in - pos + 26) mod 26.
- Handshake:
  - lut_req_out, lut_rotor_out, lut_dir_out and lut_char_out are held stable in LOOKUP until a cycle with lut_valid_in = 1.
  - On that edge the result is captured and p advances. lut_req_out stays high across consecutive passes.
  - lut_valid_in while lut_req_out = 0 is ignored.
  - After p = 6 completes, go to DONE.
- DONE (1 cycle): char_out <= result and char_valid_out = 1 for exactly one cycle, then IDLE. char_out holds its value until the next DONE.
- Latency: letter_valid_in sampled at edge k gives char_valid_out high in the cycle after edge k+9, when the lookup responds with zero wait. Each LUT wait cycle adds one.
- Reset mid-operation: returns to IDLE with all outputs 0 within one edge. An in-flight lookup is abandoned and no char_valid_out is produced.

Test Plan:
- Reset, then rotor_valid_in with select 9'b000_001_010 and initial 0 -> positions_out = 0 and busy_out = 0. Then letter A (0), with the bench LUT modelling I, II, III and reflector B -> positions_out = {0,0,1} and char_out = 1 (B) 9 cycles after the letter.
- Double step, select I, II, III, initial {0,3,21} (ADV): three letters -> positions AEW {0,4,22}, then BFX {1,5,23}, then BFY {1,5,24}.
- Right wrap, initial {0,0,25} with rotor III -> after one letter positions = {0,0,0}, middle unchanged.
- LUT waits of 3 cycles on every pass -> lut_char_out stable while waiting, char_valid_out at +30 cycles, a single pulse.
- letter_valid_in while busy, and rotor_valid_in while busy -> ignored. Exactly one char_valid_out, and positions/selection unchanged by the ignored config.
- Simultaneous rotor_valid_in (initial {0,0,5}) and letter_valid_in in IDLE -> positions {0,0,6} and encryption from the new config. char_in = 27 -> no output, no step.
- rst_in asserted at p = 4 -> next cycle busy_out = 0, lut_req_out = 0, no char_valid_out.
